// File: rtl/alarm_time_set_pkg.sv
// Shared types and constants for the alarm-time setter.
package alarm_time_set_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   typedef struct packed {
      logic               pm;
      logic [DIGIT_W-1:0] hours_msd;
      logic [DIGIT_W-1:0] hours_lsd;
      logic [DIGIT_W-1:0] minutes_msd;
      logic [DIGIT_W-1:0] minutes_lsd;
   } alarm_time_t;

   localparam logic               RESET_PM          = 1'b0;
   localparam logic [DIGIT_W-1:0] RESET_HOURS_MSD   = 4'd1;
   localparam logic [DIGIT_W-1:0] RESET_HOURS_LSD   = 4'd2;
   localparam logic [DIGIT_W-1:0] RESET_MINUTES_MSD = 4'd0;
   localparam logic [DIGIT_W-1:0] RESET_MINUTES_LSD = 4'd0;

   // BCD {msd,lsd} limits
   localparam logic [7:0] MINUTES_LIMIT = 8'h59;
   localparam logic [7:0] HOURS_LIMIT   = 8'h12;
   localparam logic [7:0] HOURS_PM_EDGE = 8'h11;

   localparam alarm_time_t RESET_TIME = '{
      pm:          RESET_PM,
      hours_msd:   RESET_HOURS_MSD,
      hours_lsd:   RESET_HOURS_LSD,
      minutes_msd: RESET_MINUTES_MSD,
      minutes_lsd: RESET_MINUTES_LSD
   };

endpackage

// File: rtl/alarm_time_set_bcd_field_inc.sv
// Combinational BCD step for one clock field: hours 12->1..11->12, minutes 00..59.
module bcd_field_inc
   import alarm_time_set_pkg::*;
(
   input  logic               hours,
   input  logic [DIGIT_W-1:0] msd,
   input  logic [DIGIT_W-1:0] lsd,
   output logic [DIGIT_W-1:0] next_msd_c,
   output logic [DIGIT_W-1:0] next_lsd_c,
   output logic               pm_toggle_c
);

   // Generic decimal carry, then field-specific wrap points
   always_comb begin
      next_msd_c  = msd;
      next_lsd_c  = DIGIT_W'(lsd + 4'd1);
      pm_toggle_c = 1'b0;
      if (lsd == 4'd9) begin
         next_msd_c = DIGIT_W'(msd + 4'd1);
         next_lsd_c = 4'd0;
      end
      if (hours) begin
         if ({msd, lsd} == HOURS_LIMIT) begin
            next_msd_c = 4'd0;
            next_lsd_c = 4'd1;
         end else if ({msd, lsd} == HOURS_PM_EDGE) begin
            pm_toggle_c = 1'b1;
         end
      end else if ({msd, lsd} == MINUTES_LIMIT) begin
         next_msd_c = 4'd0;
         next_lsd_c = 4'd0;
      end
   end

endmodule

// File: rtl/alarm_time_set.sv
// Button-driven alarm time writer (12-hour BCD + PM flag).
// Auto-repeat (HOLD/REPEAT states, hold counter) is built only when
// ALARM_TIME_SET_AUTOREPEAT_EN is defined; otherwise a press steps once and
// waits for full release.
module alarm_time_set
   import alarm_time_set_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY = 2
) (
   input  logic               clk_fast,
   input  logic               reset,
   input  logic               en,
   input  logic               tick_1hz,
   input  logic               set_hours,
   input  logic               set_minutes,
   output logic               alarm_pm,
   output logic [DIGIT_W-1:0] alarm_hours_msd,
   output logic [DIGIT_W-1:0] alarm_hours_lsd,
   output logic [DIGIT_W-1:0] alarm_minutes_msd,
   output logic [DIGIT_W-1:0] alarm_minutes_lsd,
   output logic [DIGIT_W-1:0] alarm_seconds_msd,
   output logic [DIGIT_W-1:0] alarm_seconds_lsd,
   output logic               alarm_changed
);

   state_t      state, state_nxt;
   alarm_time_t time_q, time_nxt, time_inc_c;
   logic        changed_q, changed_nxt;
   logic        en_q, btn_h_q, btn_m_q, prev_h_q, prev_m_q;
   logic        edge_h_c, edge_m_c, chord_c, inc_hours_c, pm_toggle_c;
   logic [DIGIT_W-1:0] inc_msd_c, inc_lsd_c, next_msd_c, next_lsd_c;

`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
   logic             tick_q, sel_hours_q, sel_hours_nxt, serviced_c;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_nxt;
`else
   logic unused_cfg;
   assign unused_cfg = ^{tick_1hz, 32'(REPEAT_DELAY)};
`endif

   // Input sampling and edge history; keeps running while disabled
   always_ff @(posedge clk_fast) begin
      if (reset) begin
         en_q     <= 1'b0;
         btn_h_q  <= 1'b0;
         btn_m_q  <= 1'b0;
         prev_h_q <= 1'b0;
         prev_m_q <= 1'b0;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
         tick_q   <= 1'b0;
`endif
      end else begin
         en_q     <= en;
         btn_h_q  <= set_hours;
         btn_m_q  <= set_minutes;
         prev_h_q <= btn_h_q;
         prev_m_q <= btn_m_q;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
         tick_q   <= tick_1hz;
`endif
      end
   end

   assign edge_h_c = btn_h_q & ~prev_h_q;
   assign edge_m_c = btn_m_q & ~prev_m_q;
   assign chord_c  = btn_h_q & btn_m_q;

   // Pick the field to step: the pressed button in IDLE, else the serviced one
   always_comb begin
      inc_hours_c = edge_h_c;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
      if (state != ST_IDLE) inc_hours_c = sel_hours_q;
      serviced_c = sel_hours_q ? btn_h_q : btn_m_q;
`endif
      inc_msd_c = inc_hours_c ? time_q.hours_msd : time_q.minutes_msd;
      inc_lsd_c = inc_hours_c ? time_q.hours_lsd : time_q.minutes_lsd;
   end

   bcd_field_inc u_inc (
      .hours       (inc_hours_c),
      .msd         (inc_msd_c),
      .lsd         (inc_lsd_c),
      .next_msd_c  (next_msd_c),
      .next_lsd_c  (next_lsd_c),
      .pm_toggle_c (pm_toggle_c)
   );

   // Time word with the selected field stepped
   always_comb begin
      time_inc_c = time_q;
      if (inc_hours_c) begin
         time_inc_c.hours_msd = next_msd_c;
         time_inc_c.hours_lsd = next_lsd_c;
         time_inc_c.pm        = time_q.pm ^ pm_toggle_c;
      end else begin
         time_inc_c.minutes_msd = next_msd_c;
         time_inc_c.minutes_lsd = next_lsd_c;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt   = state;
      time_nxt    = time_q;
      changed_nxt = 1'b0;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
      hold_cnt_nxt  = hold_cnt_q;
      sel_hours_nxt = sel_hours_q;
`endif
      if (!en_q) begin
         state_nxt = ST_IDLE;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
         hold_cnt_nxt = '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (chord_c && (edge_h_c || edge_m_c)) begin
                  time_nxt    = RESET_TIME;
                  changed_nxt = 1'b1;
                  state_nxt   = ST_LOCK;
               end else if (edge_h_c || edge_m_c) begin
                  time_nxt    = time_inc_c;
                  changed_nxt = 1'b1;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
                  state_nxt     = ST_HOLD;
                  hold_cnt_nxt  = '0;
                  sel_hours_nxt = edge_h_c;
`else
                  state_nxt   = ST_LOCK;
`endif
               end
            end
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
            ST_HOLD, ST_REPEAT: begin
               if (chord_c) begin
                  time_nxt    = RESET_TIME;
                  changed_nxt = 1'b1;
                  state_nxt   = ST_LOCK;
               end else if (!serviced_c) begin
                  state_nxt = ST_IDLE;
               end else if (tick_q) begin
                  if (state == ST_REPEAT ||
                      CNT_W'(hold_cnt_q + 1'b1) == CNT_W'(REPEAT_DELAY)) begin
                     time_nxt    = time_inc_c;
                     changed_nxt = 1'b1;
                     state_nxt   = ST_REPEAT;
                  end else begin
                     hold_cnt_nxt = CNT_W'(hold_cnt_q + 1'b1);
                  end
               end
            end
`endif
            ST_LOCK: begin
               if (!btn_h_q && !btn_m_q) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk_fast) begin
      if (reset) begin
         state     <= ST_IDLE;
         time_q    <= RESET_TIME;
         changed_q <= 1'b0;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
         hold_cnt_q  <= '0;
         sel_hours_q <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         time_q    <= time_nxt;
         changed_q <= changed_nxt;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
         hold_cnt_q  <= hold_cnt_nxt;
         sel_hours_q <= sel_hours_nxt;
`endif
      end
   end

   assign alarm_pm          = time_q.pm;
   assign alarm_hours_msd   = time_q.hours_msd;
   assign alarm_hours_lsd   = time_q.hours_lsd;
   assign alarm_minutes_msd = time_q.minutes_msd;
   assign alarm_minutes_lsd = time_q.minutes_lsd;
   assign alarm_seconds_msd = 4'd0;
   assign alarm_seconds_lsd = 4'd0;
   assign alarm_changed     = changed_q;

endmodule

// File: tb/tb_alarm_time_set.sv
// Self-checking bench for alarm_time_set with a behavioural reference model.
module tb_alarm_time_set;

   localparam int RD = 2;
`ifdef ALARM_TIME_SET_AUTOREPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk_fast = 1'b0;
   logic reset = 1'b1, en = 1'b1, tick_1hz = 1'b0;
   logic set_hours = 1'b0, set_minutes = 1'b0;
   logic alarm_pm, alarm_changed;
   logic [3:0] alarm_hours_msd, alarm_hours_lsd, alarm_minutes_msd, alarm_minutes_lsd;
   logic [3:0] alarm_seconds_msd, alarm_seconds_lsd;

   int tests = 0, fails = 0;
   int dut_pulses = 0, mdl_pulses = 0;

   // reference model: plain integer time plus button bookkeeping
   int m_hours = 12, m_min = 0;
   bit m_pm = 0, m_changed = 0;
   int serv = 0;        // 0 none, 1 hours, 2 minutes
   bit locked = 0, rep = 0;
   int held = 0;
   bit r_en = 0, r_tick = 0, r_h = 0, r_m = 0, p_h = 0, p_m = 0;

   alarm_time_set #(.REPEAT_DELAY(RD)) dut (
      .clk_fast(clk_fast), .reset(reset), .en(en), .tick_1hz(tick_1hz),
      .set_hours(set_hours), .set_minutes(set_minutes),
      .alarm_pm(alarm_pm),
      .alarm_hours_msd(alarm_hours_msd), .alarm_hours_lsd(alarm_hours_lsd),
      .alarm_minutes_msd(alarm_minutes_msd), .alarm_minutes_lsd(alarm_minutes_lsd),
      .alarm_seconds_msd(alarm_seconds_msd), .alarm_seconds_lsd(alarm_seconds_lsd),
      .alarm_changed(alarm_changed)
   );

   always #5 clk_fast = ~clk_fast;

   function automatic logic [16:0] obs_word();
      return {alarm_pm, alarm_hours_msd, alarm_hours_lsd, alarm_minutes_msd, alarm_minutes_lsd};
   endfunction

   function automatic logic [16:0] to_word(input int h, input int m, input bit pm);
      return {pm, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   task automatic bump(input bit hrs);
      m_changed = 1;
      if (hrs) begin
         m_hours = m_hours % 12 + 1;
         if (m_hours == 12) m_pm = ~m_pm;
      end else begin
         m_min = (m_min + 1) % 60;
      end
   endtask

   task automatic clear_all();
      m_hours = 12; m_min = 0; m_pm = 0; m_changed = 1;
      serv = 0; locked = 1;
   endtask

   // one rising edge of the model; inputs seen one cycle late
   task automatic model_step();
      bit eh, em;
      if (reset) begin
         m_hours = 12; m_min = 0; m_pm = 0; m_changed = 0;
         serv = 0; locked = 0; held = 0; rep = 0;
         r_en = 0; r_tick = 0; r_h = 0; r_m = 0; p_h = 0; p_m = 0;
         return;
      end
      m_changed = 0;
      eh = r_h && !p_h;
      em = r_m && !p_m;
      if (!r_en) begin
         serv = 0; locked = 0; held = 0; rep = 0;
      end else if (locked) begin
         if (!r_h && !r_m) locked = 0;
      end else if (serv == 0) begin
         if (r_h && r_m && (eh || em)) clear_all();
         else if (eh || em) begin
            bump(eh);
            if (AUTO) begin serv = eh ? 1 : 2; held = 0; rep = 0; end
            else locked = 1;
         end
      end else begin
         if (r_h && r_m) clear_all();
         else if ((serv == 1 && !r_h) || (serv == 2 && !r_m)) serv = 0;
         else if (r_tick) begin
            if (rep) bump(serv == 1);
            else begin
               held++;
               if (held == RD) begin bump(serv == 1); rep = 1; end
            end
         end
      end
      p_h = r_h; p_m = r_m;
      r_h = set_hours; r_m = set_minutes; r_en = en; r_tick = tick_1hz;
   endtask

   task automatic step();
      @(posedge clk_fast);
      model_step();
      #1;
      if (alarm_changed) dut_pulses++;
      if (m_changed) mdl_pulses++;
   endtask

   task automatic do_reset();
      reset = 1; en = 1; tick_1hz = 0; set_hours = 0; set_minutes = 0;
      repeat (2) step();
      reset = 0;
   endtask

   task automatic press(input bit hrs);
      if (hrs) set_hours = 1; else set_minutes = 1;
      repeat (3) step();
      set_hours = 0; set_minutes = 0;
      repeat (3) step();
   endtask

   task automatic tick();
      tick_1hz = 1; step(); tick_1hz = 0; repeat (3) step();
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if (obs_word() !== to_word(12, 0, 0)) begin
         fails++; $display("FAIL reset_time got %h want %h", obs_word(), to_word(12, 0, 0));
      end
      tests++;
      if (alarm_changed !== 1'b0) begin
         fails++; $display("FAIL reset_changed got %b want 0", alarm_changed);
      end
      tests++;
      if ({alarm_seconds_msd, alarm_seconds_lsd} !== 8'h00) begin
         fails++; $display("FAIL seconds got %h%h want 00", alarm_seconds_msd, alarm_seconds_lsd);
      end
   endtask

   task automatic test_minutes_press();
      int p0;
      do_reset();
      p0 = dut_pulses;
      set_minutes = 1; step();
      tests++;
      if (alarm_changed !== 1'b0) begin
         fails++; $display("FAIL press_latency_early got %b want 0", alarm_changed);
      end
      step();
      tests++;
      if (alarm_changed !== 1'b1 || obs_word() !== to_word(12, 1, 0)) begin
         fails++; $display("FAIL press_latency got chg=%b %h want chg=1 %h", alarm_changed, obs_word(), to_word(12, 1, 0));
      end
      step(); set_minutes = 0; repeat (4) step();
      tests++;
      if (obs_word() !== to_word(12, 1, 0) || dut_pulses - p0 !== 1) begin
         fails++; $display("FAIL minutes_press got %h pulses %0d want %h pulses 1", obs_word(), dut_pulses - p0, to_word(12, 1, 0));
      end
      press(0);
      tests++;
      if (obs_word() !== to_word(12, 2, 0)) begin
         fails++; $display("FAIL back_to_idle got %h want %h", obs_word(), to_word(12, 2, 0));
      end
   endtask

   task automatic test_minutes_wrap();
      do_reset();
      repeat (59) press(0);
      tests++;
      if (obs_word() !== to_word(12, 59, 0)) begin
         fails++; $display("FAIL minutes_59 got %h want %h", obs_word(), to_word(12, 59, 0));
      end
      press(0);
      tests++;
      if (obs_word() !== to_word(12, 0, 0)) begin
         fails++; $display("FAIL minutes_wrap got %h want %h", obs_word(), to_word(12, 0, 0));
      end
   endtask

   task automatic test_hours_seq();
      do_reset();
      repeat (11) press(1);
      tests++;
      if (obs_word() !== to_word(11, 0, 0)) begin
         fails++; $display("FAIL hours_11 got %h want %h", obs_word(), to_word(11, 0, 0));
      end
      press(1);
      tests++;
      if (obs_word() !== to_word(12, 0, 1)) begin
         fails++; $display("FAIL hours_12pm got %h want %h", obs_word(), to_word(12, 0, 1));
      end
      press(1);
      tests++;
      if (obs_word() !== to_word(1, 0, 1)) begin
         fails++; $display("FAIL hours_1pm got %h want %h", obs_word(), to_word(1, 0, 1));
      end
   endtask

   task automatic test_autorepeat();
      int want;
      want = AUTO ? 5 : 1;
      do_reset();
      set_minutes = 1; repeat (3) step();
      repeat (5) tick();
      set_minutes = 0; repeat (3) step();
      tests++;
      if (obs_word() !== to_word(12, want, 0)) begin
         fails++; $display("FAIL autorepeat got %h want %h", obs_word(), to_word(12, want, 0));
      end
      // press coinciding with a tick: exactly one step
      set_hours = 1; tick_1hz = 1; step(); tick_1hz = 0; step();
      tick_1hz = 1; step(); tick_1hz = 0; repeat (2) step();
      set_hours = 0; repeat (3) step();
      tests++;
      if (obs_word() !== to_word(1, want, 0)) begin
         fails++; $display("FAIL press_with_tick got %h want %h", obs_word(), to_word(1, want, 0));
      end
   endtask

   task automatic test_chord();
      int p0;
      do_reset();
      repeat (15) press(1);
      repeat (27) press(0);
      tests++;
      if (obs_word() !== to_word(3, 27, 1)) begin
         fails++; $display("FAIL chord_setup got %h want %h", obs_word(), to_word(3, 27, 1));
      end
      set_hours = 1; repeat (4) step();
      p0 = dut_pulses;
      set_minutes = 1; repeat (3) step();
      tests++;
      if (obs_word() !== (AUTO ? to_word(12, 0, 0) : to_word(4, 27, 1)) ||
          dut_pulses - p0 !== (AUTO ? 1 : 0)) begin
         fails++; $display("FAIL chord_held got %h pulses %0d", obs_word(), dut_pulses - p0);
      end
      p0 = dut_pulses;
      repeat (3) tick();
      set_minutes = 0; repeat (2) tick();
      set_hours = 0; repeat (3) step();
      tests++;
      if (dut_pulses - p0 !== 0 || obs_word() !== to_word(m_hours, m_min, m_pm)) begin
         fails++; $display("FAIL chord_lock got pulses %0d %h", dut_pulses - p0, obs_word());
      end
      press(0);
      p0 = dut_pulses;
      set_hours = 1; set_minutes = 1; repeat (3) step();
      tick();
      set_hours = 0; set_minutes = 0; repeat (3) step();
      tests++;
      if (obs_word() !== to_word(12, 0, 0) || dut_pulses - p0 !== 1) begin
         fails++; $display("FAIL chord_simultaneous got %h pulses %0d want %h pulses 1", obs_word(), dut_pulses - p0, to_word(12, 0, 0));
      end
   endtask

   task automatic test_enable();
      int p0;
      do_reset();
      p0 = dut_pulses;
      en = 0; step();
      set_hours = 1;
      repeat (3) tick();
      tests++;
      if (obs_word() !== to_word(12, 0, 0) || dut_pulses - p0 !== 0) begin
         fails++; $display("FAIL en_low got %h pulses %0d want %h pulses 0", obs_word(), dut_pulses - p0, to_word(12, 0, 0));
      end
      en = 1;
      repeat (3) tick();
      tests++;
      if (obs_word() !== to_word(12, 0, 0) || dut_pulses - p0 !== 0) begin
         fails++; $display("FAIL en_rise_held got %h pulses %0d want %h pulses 0", obs_word(), dut_pulses - p0, to_word(12, 0, 0));
      end
      set_hours = 0; repeat (2) step();
      press(1);
      tests++;
      if (obs_word() !== to_word(1, 0, 0)) begin
         fails++; $display("FAIL en_after got %h want %h", obs_word(), to_word(1, 0, 0));
      end
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      set_minutes = 1; repeat (3) step();
      repeat (4) tick();
      reset = 1; step();
      tests++;
      if (obs_word() !== to_word(12, 0, 0) || alarm_changed !== 1'b0) begin
         fails++; $display("FAIL reset_mid_hold got %h chg=%b want %h chg=0", obs_word(), alarm_changed, to_word(12, 0, 0));
      end
      reset = 0; set_minutes = 0; repeat (3) step();
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(0, 299) == 0);
         en       = ($urandom_range(0, 19) != 0);
         tick_1hz = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) set_hours = ~set_hours;
         if ($urandom_range(0, 9) == 0) set_minutes = ~set_minutes;
         step();
         tests++;
         if (obs_word() !== to_word(m_hours, m_min, m_pm) || alarm_changed !== m_changed) begin
            fails++; errs++;
            if (errs <= 10)
               $display("FAIL random cyc %0d got %h chg=%b want %h chg=%b", i, obs_word(), alarm_changed, to_word(m_hours, m_min, m_pm), m_changed);
         end
      end
      reset = 0; en = 1; tick_1hz = 0; set_hours = 0; set_minutes = 0;
      repeat (3) step();
      tests++;
      if (dut_pulses !== mdl_pulses) begin
         fails++; $display("FAIL pulse_total got %0d want %0d", dut_pulses, mdl_pulses);
      end
   endtask

   initial begin
      test_reset();
      test_minutes_press();
      test_minutes_wrap();
      test_hours_seq();
      test_autorepeat();
      test_chord();
      test_enable();
      test_reset_mid_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alarm_time_set.md
# alarm_time_set

Button-driven writer for the alarm setting consumed by the alarm comparator: holds the alarm time as 12-hour BCD digits plus a PM flag, and steps hours or minutes from debounced push-buttons. Auto-repeat applies while a button is held, and a two-button chord clears the setting. Sits between the debounced user inputs and the `alarm_*` inputs of the alarm comparison/countdown logic, in the fast clock domain.

## Interface
- `REPEAT_DELAY`, default 2: number of `tick_1hz` strobes a button must be held before auto-repeat starts; legal range 1..15.
- `clk_fast`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  block enable; when low, buttons are ignored.
- `tick_1hz`  in  1  single-cycle strobe, once per second, synchronous to `clk_fast`.
- `set_hours`  in  1  debounced level, high while the hours button is held.
- `set_minutes`  in  1  debounced level, high while the minutes button is held.
- `alarm_pm`  out  1  PM flag.
- `alarm_hours_msd`, `alarm_hours_lsd`  out  4 each  BCD hours, 1..12.
- `alarm_minutes_msd`, `alarm_minutes_lsd`  out  4 each  BCD minutes, 00..59.
- `alarm_seconds_msd`, `alarm_seconds_lsd`  out  4 each  constant 0.
- `alarm_changed`  out  1  one-cycle pulse on every cycle the setting is written.

## Operation
- Reset values:
  - Time is 12:00:00 AM: `alarm_pm`=0, hours digits=1/2, minutes=0/0, `alarm_changed`=0.
  - FSM is in IDLE.
  - Both button edge-history registers are 0.
- Each button is registered once for edge detection. A press edge is current=1 with previous=0.
- FSM states:
  - **IDLE** — no button is being serviced.
    - Press edge on exactly one button: increment that field and go to HOLD. The hold counter clears to 0.
    - Both buttons high in the same cycle, whether by simultaneous edges or a second press during HOLD/REPEAT: clear to 12:00 AM, pulse `alarm_changed`, and go to LOCK.
  - **HOLD** — the button is held, waiting for auto-repeat.
    - Each `tick_1hz` increments the hold counter.
    - When the counter reaches `REPEAT_DELAY` on a tick, increment the field and go to REPEAT.
    - Release of the serviced button: go to IDLE.
  - **REPEAT** — each `tick_1hz` increments the field. Release: go to IDLE.
  - **LOCK** — no increments. Go to IDLE only when both buttons are low.
- Hours sequence: 12→1→…→11→12.
  - 11→12 toggles `alarm_pm`.
  - 12→1 does not toggle `alarm_pm`.
- Minutes sequence: 00→…→59→00. There is no carry into hours.
- Seconds outputs are tied to 0.
- A press edge and `tick_1hz` in the same cycle give exactly one increment. That tick is not counted by the hold counter.
- `en`=0:
  - FSM is forced to IDLE and the hold counter clears.
  - The time registers hold their values.
  - The edge history keeps sampling, so a button already held when `en` rises does not produce an edge.
- Reset mid-hold or mid-repeat returns the block to reset values the next cycle, regardless of button state.

## Timing
- Press latency: a button first sampled high at edge N produces updated outputs and `alarm_changed`=1 after edge N+1.
- Repeat latency: a qualifying `tick_1hz` at edge N updates the outputs after edge N+1.
- All outputs are registered, with no combinational paths from inputs to outputs.
- `alarm_changed` is high for exactly one cycle per write, including the chord clear.

## Configuration
- Macro: `ALARM_TIME_SET_AUTOREPEAT_EN`.
- Defined: HOLD and REPEAT are implemented as described above.
- Undefined:
  - HOLD and REPEAT are removed, along with the hold counter.
  - A press edge increments once and goes to LOCK, which waits for full release.
  - `tick_1hz` and `REPEAT_DELAY` are unused.

## Structure
- Shared package contents:
  - FSM state encoding: IDLE, HOLD, REPEAT, LOCK.
  - Reset-time constants: hours 1/2, minutes 0/0, PM 0.
  - BCD limits: 59 for minutes, 12 for hours.
- One sub-module, `bcd_field_inc`. It takes a BCD msd/lsd pair and a field-select input (hours or minutes), and returns the next value plus a PM-toggle flag. It is combinational and is instantiated once.

## Test plan
- Reset, then a single minutes press with release before any tick: time = 12:01 AM, one `alarm_changed` pulse, FSM returns to IDLE.
- Minutes preset to 59, one press: minutes = 00, hours stay 12.
- Hours press 11 times from reset: after the 11th press hours = 11 with PM=0; a 12th press gives 12 PM; a 13th gives 1 PM.
- Auto-repeat with `REPEAT_DELAY`=2: hold minutes through 5 ticks; the initial press plus ticks 2..5 give minutes = 05.
- Chord: set 3:27 PM, press hours then minutes while hours is held: time = 12:00 AM, one pulse, no further increments until both buttons are released.
- `en` low while holding hours through 3 ticks: no change; raise `en` with hours still held: still no increment.
